fxp_mult_pipe: RTL and testbench

Parametrised, pipelined signed fixed-point multiplier with valid/ready handshake, the successor to the team's combinational Q16.16 multiply units. It computes `a*b` in sign-magnitude form with magnitude truncation, then applies an optional arithmetic post-shift. The post-shift replaces the separate divide-by-8 variant. The block sits in the datapath between operand producers (filters, accumulators) and consumers that can apply backpressure. It also carries a sideband tag so out-of-band context stays aligned with results.

---
 rtl/fxp_pkg.sv | 32 +++
 rtl/fxp_mult_if.sv | 27 ++
 rtl/fxp_abs_sign.sv | 15 +
 rtl/fxp_mult_pipe.sv | 92 +++++++++
 tb/tb_fxp_mult_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fxp_pkg.sv
// Shared limits and range helpers for the fxp_mult_pipe datapath.
// FXP_MULT_SAT_EN selects clamping over wrap in the formatter.
package fxp_pkg;

    localparam int FXP_MAX_W = 64;
    localparam int FXP_RW    = 2 * FXP_MAX_W + 1;

    typedef logic signed [FXP_RW-1:0] fxp_wide_t;
    typedef logic [FXP_MAX_W-1:0]     fxp_word_t;

    function automatic fxp_word_t fxp_max(input int unsigned w);
        return (fxp_word_t'(1) << (w - 1)) - fxp_word_t'(1);
    endfunction

    function automatic fxp_word_t fxp_min(input int unsigned w);
        return ~fxp_max(w);
    endfunction

    // In range exactly when everything above bit w-2 is a sign copy
    function automatic logic fxp_ovf(input fxp_wide_t r, input int unsigned w);
        fxp_wide_t hi;
        hi = r >>> (w - 1);
        return !(hi == '0 || hi == '1);
    endfunction

    function automatic fxp_word_t fxp_sat(input fxp_wide_t r, input int unsigned w);
        if (!fxp_ovf(r, w))
            return fxp_word_t'(r);
        return r[FXP_RW-1] ? fxp_min(w) : fxp_max(w);
    endfunction

endpackage

// File: rtl/fxp_mult_if.sv
// Operand/result valid-ready bundle for fxp_mult_pipe.
// master = producer/consumer side, slave = multiplier side.
interface fxp_mult_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_ovf
    );
endinterface

// File: rtl/fxp_abs_sign.sv
// S1 of fxp_mult_pipe: product sign and unsigned operand magnitudes.
// The most negative input maps to 2^(WIDTH-1) without wrapping.
module fxp_abs_sign #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             sign,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b
);
    assign sign  = a[WIDTH-1] ^ b[WIDTH-1];
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;
endmodule

// File: rtl/fxp_mult_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready and tag.
// Define FXP_MULT_SAT_EN to clamp out-of-range results instead of wrapping.
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int POST_SHIFT = 0,
    parameter int TAG_W      = 4
) (
    input logic       clk,
    input logic       rst_n,
    fxp_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int RW = PW + 1;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [WIDTH-1:0] ma;
        logic [WIDTH-1:0] mb;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [PW-1:0]    mag;
        logic [TAG_W-1:0] tag;
    } s2_t;

    s1_t s1;
    s2_t s2;

    logic                 adv;
    logic                 sign;
    logic [WIDTH-1:0]     ma;
    logic [WIDTH-1:0]     mb;
    logic [PW-1:0]        m;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] rs;
    logic                 ovf;
    logic [WIDTH-1:0]     p;

    // One global enable: a held result freezes every stage, bubbles too
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv || !rst_n;

    fxp_abs_sign #(
        .WIDTH(WIDTH)
    ) u_abs (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .sign (sign),
        .mag_a(ma),
        .mag_b(mb)
    );

    always_comb begin
        m   = s2.mag >> FRAC;
        r   = s2.sign ? -$signed({1'b0, m}) : $signed({1'b0, m});
        rs  = r >>> POST_SHIFT;
        ovf = fxp_ovf(FXP_RW'(rs), WIDTH);
`ifdef FXP_MULT_SAT_EN
        p   = WIDTH'(fxp_sat(FXP_RW'(rs), WIDTH));
`else
        p   = rs[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1            <= '0;
            s2            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_p     <= '0;
            bus.out_tag   <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (adv) begin
            s1 <= '{valid: bus.in_valid, sign: sign,
                    ma: ma, mb: mb, tag: bus.in_tag};
            s2 <= '{valid: s1.valid, sign: s1.sign,
                    mag: PW'(s1.ma) * PW'(s1.mb), tag: s1.tag};
            bus.out_valid <= s2.valid;
            bus.out_p     <= p;
            bus.out_tag   <= s2.tag;
            bus.out_ovf   <= ovf;
        end
    end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Bench for fxp_mult_pipe: two instances (post-shift 0 and 3) in lockstep.
// Honours FXP_MULT_SAT_EN in its expectations.
module tb_fxp_mult_pipe;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int TW = 4;

    localparam longint PMAX = 64'sd2147483647;
    localparam longint PMIN = -64'sd2147483648;

`ifdef FXP_MULT_SAT_EN
    localparam logic [31:0] OVF_P  = 32'h7FFFFFFF;
    localparam logic [31:0] OVF2_P = 32'h7FFFFFFF;
    localparam logic [31:0] OVF3_P = 32'h80000000;
`else
    localparam logic [31:0] OVF_P  = 32'hFFFE0000;
    localparam logic [31:0] OVF2_P = 32'h00000000;
    localparam logic [31:0] OVF3_P = 32'h00000000;
`endif

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  tag;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p0;
        logic        o0;
        logic [31:0] p3;
        logic        o3;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fxp_mult_if #(.WIDTH(W), .TAG_W(TW)) bus0 ();
    fxp_mult_if #(.WIDTH(W), .TAG_W(TW)) bus3 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_a      = in_a;
    assign bus0.in_b      = in_b;
    assign bus0.in_tag    = in_tag;
    assign bus0.out_ready = out_ready;
    assign bus3.in_valid  = in_valid;
    assign bus3.in_a      = in_a;
    assign bus3.in_b      = in_b;
    assign bus3.in_tag    = in_tag;
    assign bus3.out_ready = out_ready;

    fxp_mult_pipe #(.WIDTH(W), .FRAC(F), .POST_SHIFT(0), .TAG_W(TW)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    fxp_mult_pipe #(.WIDTH(W), .FRAC(F), .POST_SHIFT(3), .TAG_W(TW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    // Reference: true product magnitude, truncate, re-sign, floor-shift, format
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input int ps, output logic [31:0] p,
                                  output logic ovf);
        longint sa, sb, r;
        longint unsigned mag;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        mag = longint'(sa < 0 ? -sa : sa) * longint'(sb < 0 ? -sb : sb);
        r   = longint'(mag >> F);
        if ((sa < 0) != (sb < 0))
            r = -r;
        r   = r >>> ps;
        ovf = (r > PMAX) || (r < PMIN);
        p   = 32'(r);
`ifdef FXP_MULT_SAT_EN
        if (ovf)
            p = (r < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] x;
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00010000};
        x = $urandom;
        case ($urandom_range(3))
            0: x = 32'($signed(x) >>> $urandom_range(30, 8));
            1: x = 32'($signed(x) >>> 12);
            2: x = corner[$urandom_range(4)];
            default: ;
        endcase
        return x;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0 || bus3.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b/%b want 0", bus0.out_valid, bus3.out_valid);
        end
        n_tests++;
        if ({bus0.out_p, bus0.out_tag, bus0.out_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got p=%h tag=%h ovf=%b want 0",
                     bus0.out_p, bus0.out_tag, bus0.out_ovf);
        end
        n_tests++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", bus0.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v [11];
        int lat;
        v = '{
            '{32'h00018000, 32'h00020000, 32'h00030000, 1'b0, 32'h00006000, 1'b0},
            '{32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0, 32'hFFFFA000, 1'b0},
            '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 32'hF0000000, 1'b0},
            '{32'h00000001, 32'h00008000, 32'h00000000, 1'b0, 32'h00000000, 1'b0},
            '{32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0, 32'h00000000, 1'b0},
            '{32'h00080000, 32'h00010000, 32'h00080000, 1'b0, 32'h00010000, 1'b0},
            '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0},
            '{32'h7FFF0000, 32'h00020000, OVF_P,        1'b1, 32'h1FFFC000, 1'b0},
            '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0},
            '{32'h80000000, 32'h80000000, OVF2_P,       1'b1, OVF2_P,       1'b1},
            '{32'h80000000, 32'h00020000, OVF3_P,       1'b1, 32'hE0000000, 1'b0}
        };
        out_ready = 1'b1;
        foreach (v[i]) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_a = v[i].a;
            in_b = v[i].b;
            in_tag = 4'(i);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!bus0.out_valid && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_tests++;
            if (lat != 3) begin
                n_fail++;
                $display("FAIL latency vec%0d got %0d want 3", i, lat);
            end
            n_tests++;
            if ({bus0.out_p, bus0.out_ovf, bus0.out_tag} !== {v[i].p0, v[i].o0, 4'(i)}) begin
                n_fail++;
                $display("FAIL vec%0d_ps0 got p=%h ovf=%b tag=%h want p=%h ovf=%b tag=%h",
                         i, bus0.out_p, bus0.out_ovf, bus0.out_tag, v[i].p0, v[i].o0, 4'(i));
            end
            n_tests++;
            if ({bus3.out_p, bus3.out_ovf} !== {v[i].p3, v[i].o3}) begin
                n_fail++;
                $display("FAIL vec%0d_ps3 got p=%h ovf=%b want p=%h ovf=%b",
                         i, bus3.out_p, bus3.out_ovf, v[i].p3, v[i].o3);
            end
        end
    endtask

    task automatic test_back_to_back(input bit rnd, input int n);
        res_t q0 [$];
        res_t q3 [$];
        res_t e;
        res_t h0;
        res_t h3;
        int sent;
        int got;
        int cyc;
        bit fire;
        bit held;
        bit extra;
        sent = 0;
        got = 0;
        cyc = 0;
        held = 1'b0;
        h0 = '0;
        h3 = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (got < n && cyc < 4000) begin
            if (!in_valid && sent < n && (!rnd || $urandom_range(3) != 0)) begin
                in_valid = 1'b1;
                in_a = rnd_op();
                in_b = rnd_op();
                in_tag = 4'(sent);
            end
            out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= 4 && cyc < 9);
            @(negedge clk);
            if (held) begin
                n_tests++;
                if (bus0.out_valid !== 1'b1
                    || {bus0.out_p, bus0.out_tag, bus0.out_ovf} !== h0
                    || {bus3.out_p, bus3.out_tag, bus3.out_ovf} !== h3) begin
                    n_fail++;
                    $display("FAIL hold_stable cyc%0d got p=%h tag=%h want p=%h tag=%h",
                             cyc, bus0.out_p, bus0.out_tag, h0.p, h0.tag);
                end
            end
            held = bus0.out_valid && !out_ready;
            h0 = {bus0.out_p, bus0.out_tag, bus0.out_ovf};
            h3 = {bus3.out_p, bus3.out_tag, bus3.out_ovf};
            if (!rnd && held) begin
                n_tests++;
                if (bus0.in_ready !== 1'b0 || bus3.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready cyc%0d got %b want 0", cyc, bus0.in_ready);
                end
            end
            fire = in_valid && bus0.in_ready;
            if (fire) begin
                e.tag = in_tag;
                model(in_a, in_b, 0, e.p, e.ovf);
                q0.push_back(e);
                model(in_a, in_b, 3, e.p, e.ovf);
                q3.push_back(e);
                sent++;
            end
            if (bus0.out_valid && out_ready) begin
                got++;
                n_tests++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_ps0 got tag=%h want none", bus0.out_tag);
                end else begin
                    e = q0.pop_front();
                    if ({bus0.out_p, bus0.out_tag, bus0.out_ovf} !== e) begin
                        n_fail++;
                        $display("FAIL stream_ps0 a=%h b=%h got p=%h tag=%h ovf=%b want p=%h tag=%h ovf=%b",
                                 in_a, in_b, bus0.out_p, bus0.out_tag, bus0.out_ovf, e.p, e.tag, e.ovf);
                    end
                end
            end
            if (bus3.out_valid && out_ready) begin
                n_tests++;
                if (q3.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_ps3 got tag=%h want none", bus3.out_tag);
                end else begin
                    e = q3.pop_front();
                    if ({bus3.out_p, bus3.out_tag, bus3.out_ovf} !== e) begin
                        n_fail++;
                        $display("FAIL stream_ps3 got p=%h tag=%h ovf=%b want p=%h tag=%h ovf=%b",
                                 bus3.out_p, bus3.out_tag, bus3.out_ovf, e.p, e.tag, e.ovf);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (fire)
                in_valid = 1'b0;
            cyc++;
        end
        n_tests++;
        if (got != n || q0.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count got %0d left %0d/%0d want %0d left 0",
                     got, q0.size(), q3.size(), n);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid || bus3.out_valid)
                extra = 1'b1;
        end
        n_tests++;
        if (extra !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_dup got extra=%b want 0", extra);
        end
    endtask

    task automatic test_reset_flight();
        bit stale;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 32'h00010000 + 32'(i);
            in_b = 32'h00020000;
            in_tag = 4'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_held got %b want 1", bus0.out_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_rst_in_ready got %b want 1", bus0.in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus0.out_valid, bus0.out_p, bus0.out_tag, bus0.out_ovf} !== '0
            || {bus3.out_valid, bus3.out_p, bus3.out_tag, bus3.out_ovf} !== '0
            || bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_reset got v=%b p=%h tag=%h rdy=%b want 0/0/0/1",
                     bus0.out_valid, bus0.out_p, bus0.out_tag, bus0.in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid || bus3.out_valid)
                stale = 1'b1;
        end
        n_tests++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL flight_stale got %b want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(1'b0, 6);
        test_back_to_back(1'b1, 300);
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
